// File: rtl/dac_spi_streamer_if.sv
// Port bundle between the sample ROM / run control and the SPI DAC streamer.
// master is the streamer side; slave is the ROM/controller/DAC side.
interface dac_spi_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  en;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_cs_n;
  logic                  frame_done;
  logic                  busy;

  modport master (
    input  en, step, rom_q,
    output rom_addr, spi_sclk, spi_mosi, spi_cs_n, frame_done, busy
  );

  modport slave (
    output en, step, rom_q,
    input  rom_addr, spi_sclk, spi_mosi, spi_cs_n, frame_done, busy
  );
endinterface

// File: rtl/dac_spi_streamer.sv
// Walks the sample ROM with a programmable address step and serialises each
// fetched word to an SPI DAC (mode 0, MSB first), one frame per sample.
module dac_spi_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_spi_streamer_if.master   bus
);

  // One shared counter covers FETCH (2 clk), SCLK half-periods and the CS gap.
  localparam int CMAX = (CLK_DIV > CS_GAP) ? ((CLK_DIV > 2) ? CLK_DIV : 2)
                                           : ((CS_GAP  > 2) ? CS_GAP  : 2);
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [BW-1:0]         bit_cnt, bit_d;
  logic [DATA_WIDTH-1:0] sr, sr_d, sr_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic                  sclk, sclk_d;
  logic                  mosi, mosi_d;
  logic                  cs_n, cs_d;
  logic                  done, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      addr    <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      sr      <= sr_d;
      addr    <= addr_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      cs_n    <= cs_d;
      done    <= done_d;
    end
  end

  assign sr_nxt = sr << 1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    sr_d    = sr;
    addr_d  = addr;
    sclk_d  = sclk;
    mosi_d  = mosi;
    cs_d    = cs_n;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) state_d = FETCH;
      end
      // Two clocks let the registered ROM output catch up with rom_addr.
      FETCH: begin
        if (cnt == CW'(1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sr_d    = bus.rom_q;
          cs_d    = 1'b0;
          mosi_d  = bus.rom_q[DATA_WIDTH-1];
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(CLK_DIV-1)) begin
          cnt_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == BW'(DATA_WIDTH-1)) begin
              // Frame end: release CS, pulse done, advance by the live step.
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
              addr_d  = addr + bus.step;
              state_d = GAP;
            end else begin
              bit_d  = bit_cnt + 1'b1;
              sr_d   = sr_nxt;
              mosi_d = sr_nxt[DATA_WIDTH-1];
            end
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(CS_GAP-1)) begin
          cnt_d   = '0;
          state_d = bus.en ? FETCH : IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_addr   = addr;
  assign bus.spi_sclk   = sclk;
  assign bus.spi_mosi   = mosi;
  assign bus.spi_cs_n   = cs_n;
  assign bus.frame_done = done;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Directed bench for dac_spi_streamer: registered ROM model plus an SPI
// monitor that reassembles every completed frame.
module tb_dac_spi_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();
  dac_spi_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLK_DIV(2), .CS_GAP(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] rom [256];
  bit         rom_rand = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rom_q <= rom_rand ? 8'($urandom) : rom[bus.rom_addr];
  end

  // Outputs only move on posedge, so edges are detected on negedge samples.
  logic       p_sclk = 1'b0, p_cs = 1'b1;
  logic [7:0] rx_w = '0;
  int         rx_bits = 0, sclk_rises = 0, cs_falls = 0;
  logic [7:0] rx_q [$];
  int         bits_q [$];
  int         done_q [$];

  always @(negedge clk) begin
    p_sclk <= bus.spi_sclk;
    p_cs   <= bus.spi_cs_n;
    if (bus.spi_sclk && !p_sclk) begin
      rx_w       <= {rx_w[6:0], bus.spi_mosi};
      rx_bits    <= rx_bits + 1;
      sclk_rises <= sclk_rises + 1;
    end
    if (!bus.spi_cs_n && p_cs) begin
      rx_w     <= '0;
      rx_bits  <= 0;
      cs_falls <= cs_falls + 1;
    end
    if (bus.spi_cs_n && !p_cs && rst_n) begin
      rx_q.push_back(rx_w);
      bits_q.push_back(rx_bits);
    end
    if (bus.frame_done) done_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    int base_r;
    rst_n = 1'b0; bus.en = 1'b1; bus.step = 8'd1; rom_rand = 1'b1;
    base_r = sclk_rises;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rom_addr, bus.spi_sclk, bus.spi_mosi, bus.spi_cs_n, bus.frame_done, bus.busy}
          !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: addr=%h sclk=%b mosi=%b cs_n=%b done=%b busy=%b, want 00 0 0 1 0 0",
                 i, bus.rom_addr, bus.spi_sclk, bus.spi_mosi, bus.spi_cs_n, bus.frame_done, bus.busy);
      end
    end
    checks++;
    if (sclk_rises != base_r) begin
      errors++; $display("FAIL reset_sclk: %0d rises, want 0", sclk_rises - base_r);
    end
    bus.en = 1'b0; rom_rand = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: %b want 0", bus.busy); end
  endtask

  task automatic test_single;
    int br, bd, bs, n;
    br = rx_q.size(); bd = done_q.size(); bs = sclk_rises;
    bus.step = 8'd1;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    checks++;
    if ({bus.spi_cs_n, bus.busy} !== 2'b11) begin
      errors++; $display("FAIL single_fetch0: cs_n/busy=%b want 11", {bus.spi_cs_n, bus.busy});
    end
    @(negedge clk);
    checks++;
    if (bus.spi_cs_n !== 1'b1) begin errors++; $display("FAIL single_fetch1: cs_n=%b want 1", bus.spi_cs_n); end
    @(negedge clk);
    checks++;
    if (bus.spi_cs_n !== 1'b0) begin errors++; $display("FAIL single_cs_fall: cs_n=%b want 0", bus.spi_cs_n); end
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.spi_cs_n) break;
      n++;
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL single_cs_window: %0d clk want 32", n); end
    checks++;
    if ({bus.frame_done, bus.rom_addr} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL single_frame_end: done=%b addr=%h want 1 01", bus.frame_done, bus.rom_addr);
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_done, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL single_gap: done/busy=%b want 01", {bus.frame_done, bus.busy});
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: %b want 0", bus.busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() - br != 1 || rx_q[$] !== 8'hA5 || bits_q[$] != 8) begin
      errors++; $display("FAIL single_word: n=%0d word=%h bits=%0d want 1 a5 8",
                         rx_q.size() - br, rx_q[$], bits_q[$]);
    end
    checks++;
    if (sclk_rises - bs != 8 || done_q.size() - bd != 1) begin
      errors++; $display("FAIL single_counts: rises=%0d dones=%0d want 8 1", sclk_rises - bs, done_q.size() - bd);
    end
  endtask

  task automatic test_continuous;
    int br, bd;
    logic [7:0] exp [5];
    exp = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rom[0] = 8'h00; bus.step = 8'h40;
    br = rx_q.size(); bd = done_q.size();
    bus.en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_q.size() - bd >= 5) break;
    end
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() - br != 5 || done_q.size() - bd != 5) begin
      errors++; $display("FAIL cont_frames: words=%0d dones=%0d want 5 5", rx_q.size() - br, done_q.size() - bd);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[br+i] !== exp[i]) begin
          errors++; $display("FAIL cont_word%0d: %h want %h", i, rx_q[br+i], exp[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (done_q[bd+i] - done_q[bd+i-1] != 36) begin
          errors++; $display("FAIL cont_period%0d: %0d want 36", i, done_q[bd+i] - done_q[bd+i-1]);
        end
      end
    end
    checks++;
    if (bus.rom_addr !== 8'h40) begin errors++; $display("FAIL cont_addr: %h want 40", bus.rom_addr); end
  endtask

  task automatic test_en_drop;
    int br, bs, bc;
    br = rx_q.size(); bs = sclk_rises; bc = cs_falls;
    bus.en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk_rises - bs >= 3) break;
    end
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() - br != 1 || rx_q[$] !== 8'h40 || bits_q[$] != 8) begin
      errors++; $display("FAIL endrop_word: n=%0d word=%h bits=%0d want 1 40 8",
                         rx_q.size() - br, rx_q[$], bits_q[$]);
    end
    checks++;
    if (bus.rom_addr !== 8'h80) begin errors++; $display("FAIL endrop_addr: %h want 80", bus.rom_addr); end
    repeat (50) @(negedge clk);
    checks++;
    if (cs_falls - bc != 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL endrop_idle: cs_falls=%0d busy=%b want 1 0", cs_falls - bc, bus.busy);
    end
  endtask

  task automatic test_step_change;
    bit moved, seen;
    moved = 1'b0; seen = 1'b0;
    bus.step = 8'd1;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rom_addr !== 8'h80) moved = 1'b1;
    end
    bus.step = 8'd5;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin seen = 1'b1; break; end
      if (bus.rom_addr !== 8'h80) moved = 1'b1;
    end
    checks++;
    if (!seen || bus.rom_addr !== 8'h85) begin
      errors++; $display("FAIL step_addr: seen=%b addr=%h want 1 85", seen, bus.rom_addr);
    end
    checks++;
    if (moved) begin errors++; $display("FAIL step_early: addr moved before frame end, want held at 80"); end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q[$] !== 8'h80) begin errors++; $display("FAIL step_word: %h want 80", rx_q[$]); end
  endtask

  task automatic test_reset_mid;
    int br, bs;
    rom[8'h85] = 8'hFF; rom[0] = 8'h3C;
    br = rx_q.size(); bs = sclk_rises;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk_rises - bs >= 5) break;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi} !== 3'b100) begin
      errors++; $display("FAIL rstmid_spi: cs_n/sclk/mosi=%b want 100", {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi});
    end
    checks++;
    if ({bus.rom_addr, bus.busy, bus.frame_done} !== {8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstmid_ctl: addr=%h busy=%b done=%b want 00 0 0", bus.rom_addr, bus.busy, bus.frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() - br != 1 || rx_q[$] !== 8'h3C || bits_q[$] != 8) begin
      errors++; $display("FAIL rstmid_restart: n=%0d word=%h bits=%0d want 1 3c 8",
                         rx_q.size() - br, rx_q[$], bits_q[$]);
    end
    checks++;
    if (bus.rom_addr !== 8'h05) begin errors++; $display("FAIL rstmid_addr: %h want 05", bus.rom_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[0] = 8'hA5;
    bus.en = 1'b0; bus.step = 8'd1;
    test_reset();
    test_single();
    test_continuous();
    test_en_drop();
    test_step_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_spi_streamer.md
# dac_spi_streamer

Waveform playback engine that walks the address space of the registered-output sample ROM and serialises each fetched sample to an external SPI DAC. It sits directly downstream of the ROM. It drives the ROM address, captures the ROM data word once per frame, and shifts that word out MSB-first in SPI mode 0. The per-frame address increment is programmable, so the playback rate is adjustable in the style of a DDS.

## Interface
- DATA_WIDTH, 8, sample width; must equal the ROM data width.
- ADDR_WIDTH, 8, ROM address width.
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1).
- CS_GAP, 2, clk cycles cs_n is held high between frames (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request; sampled every clk.
- step  in  ADDR_WIDTH  address increment; sampled at the frame-end edge.
- rom_addr  out  ADDR_WIDTH  registered ROM address.
- rom_q  in  DATA_WIDTH  ROM registered read data (1-clk latency from rom_addr).
- spi_sclk  out  1  SPI clock, idle low.
- spi_mosi  out  1  serial data, MSB first.
- spi_cs_n  out  1  DAC chip select, active low.
- frame_done  out  1  one-clk pulse at the end of each frame.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Reset values (asserted asynchronously, held while rst_n=0): state=IDLE, rom_addr=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, frame_done=0, busy=0, shift register=0, all counters=0.
- IDLE: outputs idle. Goes to FETCH at the edge where en=1 is sampled.
- FETCH: exactly 2 clk, which guarantees rom_q reflects rom_addr. At the edge that ends FETCH:
  - shift_reg ← rom_q;
  - spi_cs_n ← 0;
  - spi_mosi ← rom_q[DATA_WIDTH-1];
  - spi_sclk stays 0;
  - go to SHIFT.
- SHIFT: for each bit, spi_sclk is low for CLK_DIV clk, then high for CLK_DIV clk.
  - At the edge ending a high phase that is not the last bit: spi_sclk ← 0 and spi_mosi ← next bit (MSB→LSB).
  - At the edge ending the last bit's high phase:
    - spi_sclk ← 0, spi_cs_n ← 1, spi_mosi ← 0;
    - frame_done ← 1 for one clk;
    - rom_addr ← (rom_addr + step) mod 2^ADDR_WIDTH, using the step value sampled at that edge;
    - go to GAP.
- GAP: CS_GAP clk with spi_cs_n=1. At its end, go to FETCH if en=1, else IDLE.
- rom_q is sampled only at the FETCH→SHIFT edge. Any change on rom_q during SHIFT or GAP is ignored.
- en is not a frame abort. Deasserting en during FETCH/SHIFT/GAP completes the current frame (FETCH always proceeds to SHIFT). The block then returns to IDLE after GAP.
- rom_addr holds its value while in IDLE. Re-enabling resumes from the current address, not from 0.
- Address wrap is natural modulo 2^ADDR_WIDTH. step=0 replays the same sample indefinitely.

## Timing
- Start latency: en sampled high at edge E0 → spi_cs_n falls at E0+2.
- cs_n low window per frame: exactly 2·CLK_DIV·DATA_WIDTH clk (32 at defaults).
- Continuous frame period (en held high): 2 + 2·CLK_DIV·DATA_WIDTH + CS_GAP clk (36 at defaults).
- The DAC samples spi_mosi on each spi_sclk rising edge. spi_mosi is stable for CLK_DIV clk before and after each rising edge.
- frame_done rises on the same edge that spi_cs_n rises.
- rom_addr changes only on frame-end edges. It is stable for ≥ CS_GAP+2 ≥ 3 edges before the next capture.
- Reset mid-frame: all outputs take their reset values immediately, with no partial frame completion. After rst_n deasserts, the block restarts from IDLE with rom_addr=0.

## Test plan
- Reset: rst_n=0 with en=1 and random rom_q → all outputs hold their reset values; no spi_sclk toggles.
- Single frame: ROM[0]=0xA5, step=1, en high for one clk →
  - spi_cs_n falls 2 clk later;
  - 8 SCLK rising edges capture bits 1,0,1,0,0,1,0,1;
  - cs_n stays low for 32 clk;
  - frame_done pulses once;
  - rom_addr=1;
  - busy clears after 2 GAP clk.
- Continuous with wrap: step=0x40, en held high, ROM[a]=a →
  - transmitted samples are 0x00, 0x40, 0x80, 0xC0, 0x00;
  - frame_done pulses are exactly 36 clk apart.
- en dropped mid-SHIFT at bit 3 → all 8 bits are sent, GAP completes, state=IDLE, no further cs_n activity.
- step changed mid-frame from 1 to 5 → the current frame-end adds 5, and no earlier change to rom_addr occurs.
- Async reset pulse during SHIFT at bit 5 → spi_cs_n=1, spi_sclk=0, spi_mosi=0, rom_addr=0 within the same clk (before the next edge); clean restart on the next en.
